fetch_stage: RTL



---
 rtl/fetch_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: credit-limited instruction fetch with in-order response
// buffering, decode stall handling and branch flush/redirect.
module fetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [PC_WIDTH-1:0]   pc_plus4_out,
  output logic [DATA_WIDTH-1:0] ins_out,
  output logic                  ins_valid
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(4);
  localparam logic [CW:0] LIMIT = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] ins;
  } ibuf_t;

  logic [PC_WIDTH-1:0] fpc;
  logic [PC_WIDTH-1:0] pcq [FIFO_DEPTH];
  logic [AW-1:0]       pcq_wp;
  logic [AW-1:0]       pcq_rp;
  ibuf_t               ibuf [FIFO_DEPTH];
  logic [AW-1:0]       ib_wp;
  logic [AW-1:0]       ib_rp;
  logic [CW-1:0]       ib_count;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       discard;

  logic [CW:0] credit_used;
  logic        req_fire;
  logic        resp_drop;
  logic        resp_keep;
  logic        ib_pop;
  ibuf_t       ib_head;
  ibuf_t       ib_new;

  // Credits cover both in-flight requests and buffered words,
  // so a kept response always finds a free slot.
  always_comb begin
    credit_used    = {1'b0, outstanding} + {1'b0, ib_count};
    imem_req_valid = !branch_taken && (credit_used < LIMIT);
    imem_addr      = fpc;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_drop      = imem_resp_valid &&
                     (branch_taken || (discard != '0));
    resp_keep      = imem_resp_valid && !resp_drop;
    ib_pop         = !branch_taken && !stall && (ib_count != '0);
    ib_head        = ibuf[ib_rp];
    ib_new.pc      = pcq[pcq_rp];
    ib_new.ins     = imem_resp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc         <= RESET_PC;
      pcq_wp      <= '0;
      pcq_rp      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (branch_taken) begin
        fpc <= branch_target;
      end else if (req_fire) begin
        fpc <= fpc + STEP;
      end
      if (req_fire) begin
        pcq_wp <= pcq_wp + 1'b1;
      end
      if (imem_resp_valid) begin
        pcq_rp <= pcq_rp + 1'b1;
      end
      outstanding <= outstanding + CW'(req_fire)
                     - CW'(imem_resp_valid);
      // Every request still in flight after a redirect is stale.
      if (branch_taken) begin
        discard <= outstanding - CW'(imem_resp_valid);
      end else if (imem_resp_valid && (discard != '0)) begin
        discard <= discard - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq[pcq_wp] <= fpc;
    end
    if (resp_keep) begin
      ibuf[ib_wp] <= ib_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ib_wp    <= '0;
      ib_rp    <= '0;
      ib_count <= '0;
    end else if (branch_taken) begin
      ib_wp    <= '0;
      ib_rp    <= '0;
      ib_count <= '0;
    end else begin
      if (resp_keep) begin
        ib_wp <= ib_wp + 1'b1;
      end
      if (ib_pop) begin
        ib_rp <= ib_rp + 1'b1;
      end
      ib_count <= ib_count + CW'(resp_keep) - CW'(ib_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out       <= '0;
      pc_plus4_out <= '0;
      ins_out      <= NOP;
      ins_valid    <= 1'b0;
    end else if (branch_taken) begin
      ins_out   <= NOP;
      ins_valid <= 1'b0;
    end else if (ib_pop) begin
      pc_out       <= ib_head.pc;
      pc_plus4_out <= ib_head.pc + STEP;
      ins_out      <= ib_head.ins;
      ins_valid    <= 1'b1;
    end else if (!stall) begin
      ins_out   <= NOP;
      ins_valid <= 1'b0;
    end
  end

endmodule
